// File: rtl/mips_avalon_ram.sv
// mips_avalon_ram: Avalon-MM responder memory used as MIPS program/data store.
// Word-addressed array mapped at BASE_ADDR. Every transfer is stretched with
// waitrequest. Define MIPS_RAM_RANDOM_WAIT_EN to add 0..3 pseudo-random
// extra stall cycles per transfer (8-bit LFSR); undefined gives a fixed stall.
//
// state | meaning
// IDLE  | no transfer in progress, waiting for read/write
// BUSY  | transfer accepted, counting down stall cycles in cnt
// ACK   | access performed, waitrequest low for one cycle
module mips_avalon_ram #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [4:0] WAIT_BASE = 5'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t                  state;
    logic [4:0]              cnt;
    logic [4:0]              wait_cnt;
    logic [31:0]             mem [DEPTH];
    logic                    req;
    logic                    fire;
    logic [30:0]             diff;
    logic                    in_win;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    unused_addr;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    assign req         = read | write;
    assign waitrequest = req & (state != ACK);
    assign unused_addr = ^address[1:0];

    // Word-granular offset from the base; bit 30 flags an address below the base
    assign diff   = {1'b0, address[31:2]} - {1'b0, BASE_ADDR[31:2]};
    assign in_win = !diff[30] && (diff[29:ADDR_WIDTH] == '0);
    assign idx    = diff[ADDR_WIDTH-1:0];

`ifdef MIPS_RAM_RANDOM_WAIT_EN
    logic [7:0] lfsr;

    assign wait_cnt = WAIT_BASE + {3'b000, lfsr[1:0]};

    // Fibonacci LFSR (taps 8,6,5,4), stepped once per transfer accepted from IDLE
    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= 8'hA5;
        else if (state == IDLE && req)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
`else
    assign wait_cnt = WAIT_BASE;
`endif

    // The access happens on the edge that moves the FSM into ACK
    assign fire = !reset && req &&
                  ((state == IDLE && wait_cnt == 5'd0) ||
                   (state == BUSY && cnt == 5'd0));

    // Byte-lane write; out-of-window writes are silently dropped
    always_ff @(posedge clk) begin
        if (fire && write && in_win) begin
            for (int i = 0; i < 4; i++)
                if (byteenable[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];
        end
    end

    // Handshake FSM and read data register; write wins when both are requested
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            readdata <= '0;
        end else begin
            if (fire && read && !write)
                readdata <= in_win ? mem[idx] : 32'h0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (wait_cnt == 5'd0) begin
                            state <= ACK;
                        end else begin
                            cnt   <= wait_cnt - 5'd1;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!req)
                        state <= IDLE;
                    else if (cnt == 5'd0)
                        state <= ACK;
                    else
                        cnt <= cnt - 5'd1;
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
